// File: rtl/uart_rx_core.sv
// Oversampled UART receive engine with start/data/parity/stop framing and a
// one-entry valid/ready holding register carrying per-frame error status.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 framing_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 fe_acc;
    logic                 pe_acc;
    logic                 frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // Falling-edge reference: a start needs a high sample on an earlier tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev <= 1'b1;
        end else if (tick) begin
            rx_prev <= rx_s;
        end
    end

    always_comb begin
        cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end

    // In DATA/PARITY/STOP every transition happens at CNT_LAST, so the wrap
    // to zero doubles as the counter clear on state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            fe_acc     <= 1'b0;
            pe_acc     <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_prev && !rx_s) begin
                            state <= ST_START;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (cnt == CNT_MID) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state   <= ST_DATA;
                                bit_idx <= '0;
                                fe_acc  <= 1'b0;
                                pe_acc  <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt_next;
                        end
                    end
                    ST_DATA: begin
                        cnt <= cnt_next;
                        if (cnt == CNT_LAST) begin
                            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                            if (bit_idx == BIT_LAST) begin
                                stop_idx <= 1'b0;
                                state    <= (PARITY != 0) ? ST_PAR : ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                            end
                        end
                    end
                    ST_PAR: begin
                        cnt <= cnt_next;
                        if (cnt == CNT_LAST) begin
                            pe_acc   <= ((^shreg) ^ rx_s) != (PARITY == 2);
                            stop_idx <= 1'b0;
                            state    <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        cnt <= cnt_next;
                        if (cnt == CNT_LAST) begin
                            if (!rx_s) begin
                                fe_acc <= 1'b1;
                            end
                            if (stop_idx == STOP_LAST) begin
                                state      <= ST_IDLE;
                                busy       <= 1'b0;
                                frame_done <= 1'b1;
                            end else begin
                                stop_idx <= stop_idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A completing frame overwrites the holding register only if it is empty
    // or being consumed this cycle; otherwise the new frame is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!data_valid || data_ready) begin
                    data_out    <= shreg;
                    framing_err <= fe_acc;
                    parity_err  <= pe_acc;
                    data_valid  <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8N1 and 8E1 instances, frame-level
// scoreboard checked every cycle data_valid is high, plus literal pins.
module tb_uart_rx_core;

    localparam int TDIV    = 4;
    localparam int OS      = 16;
    localparam int BIT_CLK = OS * TDIV;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_p = 1'b1;
    logic       data_ready = 1'b0;
    logic       ready_p = 1'b1;

    logic [7:0] data_out, data_out_p;
    logic       data_valid, framing_err, parity_err, overrun_err, busy;
    logic       data_valid_p, framing_err_p, parity_err_p, overrun_err_p, busy_p;

    int tests = 0;
    int fails = 0;

    frame_t     exp_q[$];
    int         exp_ov = 0;
    int         ov_seen = 0;
    int         deliv_cnt = 0;
    int         valid_cyc = 0;
    int         busy_cyc = 0;
    logic [7:0] last_d = '0;
    logic       last_fe = 1'b0;
    logic       last_pe = 1'b0;
    logic       valid_d = 1'b0;
    logic       ready_d = 1'b0;
    int         p_deliv = 0;
    logic [7:0] p_last_d = '0;
    logic       p_last_fe = 1'b0;
    logic       p_last_pe = 1'b0;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_in),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .framing_err(framing_err), .parity_err(parity_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .tick(tick), .rx_in(rx_p),
        .data_out(data_out_p), .data_valid(data_valid_p), .data_ready(ready_p),
        .framing_err(framing_err_p), .parity_err(parity_err_p),
        .overrun_err(overrun_err_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TDIV - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Even parity: the count of ones over data plus parity bit must be even.
    function automatic logic even_par_err(input logic [7:0] d, input logic p);
        return ((($countones(d) + int'(p)) % 2) != 0);
    endfunction

    // Frame model: a completed frame is dropped only when the holding register
    // still owns an unconsumed frame and the host is not accepting.
    task automatic model_complete(input logic [7:0] d, input logic stop_bit, input bit ready_at_done);
        frame_t f;
        f.d  = d;
        f.fe = !stop_bit;
        f.pe = 1'b0;
        if (exp_q.size() != 0 && !data_ready && !ready_at_done) exp_ov++;
        else exp_q.push_back(f);
    endtask

    task automatic drive(input bit lane, input logic v);
        if (lane) rx_p = v;
        else rx_in = v;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * BIT_CLK) @(negedge clk);
    endtask

    task automatic send(input bit lane, input logic [7:0] d, input bit use_par, input logic pbit,
                        input logic stop_bit, input bit pulse_ready);
        bit seen;
        drive(lane, 1'b0);
        idle_bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(lane, d[i]);
            idle_bits(1);
        end
        if (use_par) begin
            drive(lane, pbit);
            idle_bits(1);
        end
        drive(lane, stop_bit);
        if (!lane) model_complete(d, stop_bit, pulse_ready);
        if (pulse_ready) begin
            seen = 1'b0;
            for (int i = 0; i < 2 * BIT_CLK && !seen; i++) begin
                @(posedge clk);
                #1;
                if (!busy) seen = 1'b1;
            end
            check("stop_busy_fall", 32'(seen), 1);
            if (seen) begin
                data_ready = 1'b1;
                @(posedge clk);
                #1;
                data_ready = 1'b0;
            end
            repeat (BIT_CLK / 2) @(negedge clk);
        end else begin
            idle_bits(1);
        end
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard compare and event monitor, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                valid_d = 1'b0;
                ready_d = 1'b0;
            end else begin
                if (data_valid) begin
                    valid_cyc++;
                    if (!valid_d || ready_d) begin
                        deliv_cnt++;
                        last_d  = data_out;
                        last_fe = framing_err;
                        last_pe = parity_err;
                    end
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_valid: got d=%02h fe=%0b pe=%0b expected no frame",
                                 data_out, framing_err, parity_err);
                    end else if (data_out !== exp_q[0].d || framing_err !== exp_q[0].fe ||
                                 parity_err !== exp_q[0].pe) begin
                        fails++;
                        $display("FAIL frame_check: got d=%02h fe=%0b pe=%0b expected d=%02h fe=%0b pe=%0b",
                                 data_out, framing_err, parity_err, exp_q[0].d, exp_q[0].fe, exp_q[0].pe);
                    end
                    if (data_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                end
                if (overrun_err) ov_seen++;
                if (busy) busy_cyc++;
                valid_d = data_valid;
                ready_d = data_ready;
                if (data_valid_p) begin
                    p_deliv++;
                    p_last_d  = data_out_p;
                    p_last_fe = framing_err_p;
                    p_last_pe = parity_err_p;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, v0, b0, o0;
        repeat (3) @(negedge clk);
        check("reset_state", {data_out, data_valid, framing_err, parity_err, overrun_err, busy}, 0);
        check("reset_state_p", {data_out_p, data_valid_p, framing_err_p, parity_err_p, overrun_err_p, busy_p}, 0);
        rst = 1'b0;
        idle_bits(2);

        // 8N1 0xA5, host always ready
        data_ready = 1'b1;
        d0 = deliv_cnt;
        v0 = valid_cyc;
        send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check("t1_count", deliv_cnt - d0, 1);
        check("t1_data", last_d, 8'hA5);
        check("t1_errs", {last_fe, last_pe}, 0);
        check("t1_valid_cycles", valid_cyc - v0, 1);

        // 5-tick low glitch: false start, busy for exactly 8 ticks
        b0 = busy_cyc;
        d0 = deliv_cnt;
        rx_in = 1'b0;
        repeat (5 * TDIV) @(negedge clk);
        rx_in = 1'b1;
        idle_bits(2);
        check("t2_busy_cycles", busy_cyc - b0, 8 * TDIV);
        check("t2_no_frame", deliv_cnt - d0, 0);

        // Even parity instance: 0x07 has three ones
        d0 = p_deliv;
        send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check("t3a_count", p_deliv - d0, 1);
        check("t3a_data", p_last_d, 8'h07);
        check("t3a_pe", p_last_pe, 1);
        check("t3a_pe_model", p_last_pe, even_par_err(8'h07, 1'b0));
        check("t3a_fe", p_last_fe, 0);
        send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_bits(1);
        check("t3b_count", p_deliv - d0, 2);
        check("t3b_pe", p_last_pe, 0);
        check("t3b_pe_model", p_last_pe, even_par_err(8'h07, 1'b1));

        // Low stop bit followed by a 40-bit break
        d0 = deliv_cnt;
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_bits(40);
        check("t4_count", deliv_cnt - d0, 1);
        check("t4_data", last_d, 8'h3C);
        check("t4_fe", last_fe, 1);
        check("t4_idle_in_break", busy, 0);
        rx_in = 1'b1;
        idle_bits(2);
        send(1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check("t4_recover_count", deliv_cnt - d0, 2);
        check("t4_recover_data", last_d, 8'h96);
        check("t4_recover_fe", last_fe, 0);

        // Overrun with host stalled
        data_ready = 1'b0;
        o0 = ov_seen;
        send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(2);
        check("t5_held_data", data_out, 8'h11);
        check("t5_held_valid", data_valid, 1);
        check("t5_overrun_pulses", ov_seen - o0, 1);
        check("t5_overrun_model", ov_seen, exp_ov);
        consume();
        check("t5_valid_cleared", data_valid, 0);

        // Back-to-back with ready only on the second frame's completion cycle
        data_ready = 1'b0;
        o0 = ov_seen;
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(1);
        check("t6_valid", data_valid, 1);
        check("t6_data", data_out, 8'hAA);
        check("t6_no_overrun", ov_seen - o0, 0);
        consume();
        check("t6_valid_cleared", data_valid, 0);

        // Reset in the middle of DATA with a frame held
        data_ready = 1'b0;
        send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check("t7_held_valid", data_valid, 1);
        rx_in = 1'b0;
        idle_bits(1);
        rx_in = 1'b1;
        idle_bits(3);
        check("t7_busy_pre", busy, 1);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t7_async_reset", {data_out, data_valid, framing_err, parity_err, overrun_err, busy}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        data_ready = 1'b1;
        idle_bits(2);
        d0 = deliv_cnt;
        send(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check("t7_after_count", deliv_cnt - d0, 1);
        check("t7_after_data", last_d, 8'hC3);

        check("all_delivered", exp_q.size(), 0);
        check("overrun_total", ov_seen, exp_ov);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
